dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL provide clk  input  1  rising-edge clock; the only clock domain.
REQ-002 SHALL provide rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL provide reqN_valid  input  1  request present from port N (N=0 pipeline MEM stage, N=1 debug/loader).
REQ-004 SHALL provide reqN_ready  output  1  port N request accepted in any cycle with reqN_valid && reqN_ready.
REQ-005 SHALL provide reqN_we  input  1  1 = store, 0 = load.
REQ-006 SHALL provide reqN_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL provide reqN_sext  input  1  for loads only: 1 sign-extend, 0 zero-extend.
REQ-008 SHALL provide reqN_addr  input  32  byte address.
REQ-009 SHALL provide reqN_wdata  input  32  store data, right-aligned.
REQ-010 SHALL provide reqN_rvalid  output  1  one-cycle completion pulse.
REQ-011 SHALL provide reqN_rdata  output  32  load result; valid with reqN_rvalid.
REQ-012 SHALL provide reqN_err  output  1  misaligned or illegal access; valid with reqN_rvalid.
REQ-013 SHALL provide mem_we  output  1  memory write enable.
REQ-014 SHALL provide mem_addr  output  32  memory byte address; memory indexes words by addr[31:2].
REQ-015 SHALL provide mem_wdata  output  32  memory write word.
REQ-016 SHALL provide mem_rdata  input  32  memory read word; asynchronous read.

Function
REQ-017 SHALL implement FSM states IDLE and RMW.
REQ-018 SHALL, in IDLE, grant one port combinationally.
  - Only one port valid: that port is granted.
  - Both ports valid: arbitration per REQ-031.
  - Only the granted port sees ready=1.
REQ-019 SHALL, for an accepted aligned load:
  - Drive mem_addr=reqN_addr in the accept cycle.
  - Extract the lane selected by addr[1:0]; little-endian, byte k = bits 8k+7:8k.
  - Extend per reqN_sext and register the result.
  - Pulse reqN_rvalid the next cycle (latency 1).
REQ-020 SHALL, for an accepted aligned word store:
  - Assert mem_we with mem_wdata=reqN_wdata in the accept cycle.
  - Pulse reqN_rvalid the next cycle with rdata=0.
REQ-021 SHALL, for an accepted aligned byte/half store:
  - Latch port, addr, size and wdata, then enter RMW.
  - In RMW, drive the latched address, replace the selected lanes of mem_rdata, and assert mem_we with the merged word.
  - Return to IDLE and pulse rvalid the following cycle (latency 2).
REQ-022 SHALL hold both reqN_ready low while in RMW.
REQ-023 SHALL treat the following as misaligned/illegal: half with addr[0]=1, word with addr[1:0]!=0, and size 11.
  - No mem_we.
  - rvalid and err pulse next cycle with rdata=0.
REQ-024 SHALL drive mem_we=0, mem_addr=0 and mem_wdata=0 when no access is active.
REQ-025 SHALL hold reqN_rdata between completions.
REQ-026 SHALL allow a new accept in the same cycle as the predecessor's rvalid (one load or word store per cycle).
REQ-027 SHALL return merged data for a load accepted in the cycle after RMW to the same word.
REQ-028 SHALL ignore a withdrawn, unaccepted request, leaving no state change.

Reset
REQ-029 SHALL, while rst is high, force mem_we=0 (any pending RMW write is dropped).
REQ-030 SHALL, on a clock edge with rst high, set:
  - state to IDLE;
  - rvalid, err and rdata to 0;
  - the priority pointer to port 0.

Configuration
REQ-031 SHALL select arbitration with macro DMEM_ARB_RR_EN.
  - Defined: round-robin; the last-accepted port becomes lowest priority.
  - Undefined: fixed priority, port 0 always wins and the pointer logic is absent.

Structure
REQ-032 SHALL place in shared package dmem_pkg: size_t enum (SZ_B, SZ_H, SZ_W), state_t enum, and constants WORD_BYTES=4 and NUM_PORTS=2.
REQ-033 SHALL factor lane logic into sub-module dmem_lane (combinational load extract/extend and store merge).

Verification
REQ-034 SHALL cover: mem[2]=0xDEADBEEF, port0 LW 0x8 -> ready=1 same cycle; next cycle rvalid=1, rdata=0xDEADBEEF.
REQ-035 SHALL cover: mem[1]=0x11223344, port1 SB 0x5 wdata 0xAA -> RMW writes 0x1122AA44; rvalid at accept+2; ready low in RMW.
REQ-036 SHALL cover: mem[1]=0x80010000, LH 0x6 sext=1 -> rdata 0xFFFF8001; sext=0 -> 0x00008001.
REQ-037 SHALL cover: both ports issue loads for 4 cycles -> with DMEM_ARB_RR_EN grants 0,1,0,1; without it grants 0,0,0,0.
REQ-038 SHALL cover: SW to 0x2 -> no mem_we; next cycle rvalid=1, err=1, rdata=0.
REQ-039 SHALL cover: rst high during RMW -> word unchanged, no rvalid, state IDLE.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and access-legality helper for the data-memory arbiter
package dmem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int NUM_PORTS  = 2;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_t;

    // Size encoding 2'b11 has no enum member and is always illegal.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - per-port request/completion bundle between a requester and the arbiter
interface dmem_arbiter_if;

    logic        valid;
    logic        ready;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output valid, we, size, sext, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  valid, we, size, sext, addr, wdata,
        output ready, rvalid, rdata, err
    );

endinterface

// File: rtl/dmem_lane.sv
// rtl/dmem_lane.sv - little-endian lane extract/extend for loads and lane merge for sub-word stores
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [4:0]  w_sh;
    logic [31:0] w_lane;
    logic [31:0] w_mask;
    logic [31:0] w_mask_sh;

    assign w_sh      = {i_off, 3'b000};
    assign w_lane    = i_rword >> w_sh;
    assign w_mask_sh = w_mask << w_sh;

    always_comb begin
        o_load = i_rword;
        w_mask = 32'hFFFF_FFFF;
        case (i_size)
            SZ_B: begin
                o_load = {{24{i_sext & w_lane[7]}}, w_lane[7:0]};
                w_mask = 32'h0000_00FF;
            end
            SZ_H: begin
                o_load = {{16{i_sext & w_lane[15]}}, w_lane[15:0]};
                w_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
    end

    assign o_merged = (i_rword & ~w_mask_sh) | ((i_wdata << w_sh) & w_mask_sh);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with sub-word store read-modify-write
// DMEM_ARB_RR_EN: defined selects round-robin arbitration, undefined selects fixed port-0 priority.
module dmem_arbiter (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave req0,
    dmem_arbiter_if.slave req1,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);
    import dmem_pkg::*;

    state_t      r_state;
    state_t      w_state_nx;
    logic        w_idle;
    logic        w_any;
    logic        w_sel;
    logic        w_acc;
    logic        w_bad;
    logic        w_we;
    logic        w_sext;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;

    logic        r_port;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [1:0]  w_ln_size;
    logic [1:0]  w_ln_off;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    logic        w_cmp_en;
    logic        w_cmp_port;
    logic        w_cmp_err;
    logic [31:0] w_cmp_data;

    logic        r_rvalid0;
    logic        r_rvalid1;
    logic        r_err0;
    logic        r_err1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

`ifdef DMEM_ARB_RR_EN
    logic r_prio;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_acc) begin
            r_prio <= ~w_sel;
        end
    end

    always_comb begin
        w_sel = ~req0.valid;
        if (req0.valid && req1.valid) begin
            w_sel = r_prio;
        end
    end
`else
    always_comb begin
        w_sel = ~req0.valid;
    end
`endif

    assign w_idle = (r_state == ST_IDLE);
    assign w_any  = req0.valid | req1.valid;
    assign w_acc  = w_idle & w_any & ~rst;

    assign req0.ready = w_acc & ~w_sel;
    assign req1.ready = w_acc & w_sel;

    assign w_we    = w_sel ? req1.we    : req0.we;
    assign w_sext  = w_sel ? req1.sext  : req0.sext;
    assign w_size  = w_sel ? req1.size  : req0.size;
    assign w_addr  = w_sel ? req1.addr  : req0.addr;
    assign w_wdata = w_sel ? req1.wdata : req0.wdata;
    assign w_bad   = is_illegal(w_size, w_addr[1:0]);

    // Loads use the live request's lane; the RMW merge uses the latched store.
    assign w_ln_size = w_idle ? w_size       : r_size;
    assign w_ln_off  = w_idle ? w_addr[1:0]  : r_addr[1:0];

    dmem_lane u_lane (
        .i_size   (w_ln_size),
        .i_sext   (w_sext),
        .i_off    (w_ln_off),
        .i_rword  (mem_rdata),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_comb begin
        w_state_nx = r_state;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        w_cmp_en   = 1'b0;
        w_cmp_port = r_port;
        w_cmp_err  = 1'b0;
        w_cmp_data = 32'h0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    w_cmp_port = w_sel;
                    if (w_bad) begin
                        w_cmp_en  = 1'b1;
                        w_cmp_err = 1'b1;
                    end else if (!w_we) begin
                        mem_addr   = w_addr;
                        w_cmp_en   = 1'b1;
                        w_cmp_data = w_load;
                    end else if (w_size == SZ_W) begin
                        mem_addr  = w_addr;
                        mem_we    = 1'b1;
                        mem_wdata = w_wdata;
                        w_cmp_en  = 1'b1;
                    end else begin
                        mem_addr   = w_addr;
                        w_state_nx = ST_RMW;
                    end
                end
            end
            ST_RMW: begin
                mem_addr   = r_addr;
                mem_wdata  = w_merged;
                mem_we     = ~rst;
                w_cmp_en   = 1'b1;
                w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata0  <= 32'h0;
            r_rdata1  <= 32'h0;
            r_port    <= 1'b0;
            r_size    <= 2'b00;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
        end else begin
            r_state   <= w_state_nx;
            r_rvalid0 <= w_cmp_en & ~w_cmp_port;
            r_rvalid1 <= w_cmp_en & w_cmp_port;
            r_err0    <= w_cmp_en & ~w_cmp_port & w_cmp_err;
            r_err1    <= w_cmp_en & w_cmp_port & w_cmp_err;
            if (w_cmp_en && !w_cmp_port) begin
                r_rdata0 <= w_cmp_data;
            end
            if (w_cmp_en && w_cmp_port) begin
                r_rdata1 <= w_cmp_data;
            end
            if (w_idle && w_state_nx == ST_RMW) begin
                r_port  <= w_sel;
                r_addr  <= w_addr;
                r_size  <= w_size;
                r_wdata <= w_wdata;
            end
        end
    end

    assign req0.rvalid = r_rvalid0;
    assign req1.rvalid = r_rvalid1;
    assign req0.err    = r_err0;
    assign req1.err    = r_err1;
    assign req0.rdata  = r_rdata0;
    assign req1.rdata  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_pkg::*;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_arbiter_if req0_if ();
    dmem_arbiter_if req1_if ();

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0_if),
        .req1      (req1_if),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        else if (bd_we) mem[bd_idx] <= bd_data;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        prio;
    logic [31:0] last_rd [2];

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic we, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            req0_if.valid = v; req0_if.we = we; req0_if.size = sz;
            req0_if.sext = sx; req0_if.addr = a; req0_if.wdata = wd;
        end else begin
            req1_if.valid = v; req1_if.we = we; req1_if.size = sz;
            req1_if.sext = sx; req1_if.addr = a; req1_if.wdata = wd;
        end
    endtask

    task automatic idle_ports();
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic poke(input int i, input logic [31:0] d);
        bd_we = 1'b1; bd_idx = 6'(i); bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        idle_ports();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        prio = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
    endtask

    // Reference rules, expressed byte by byte.
    function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] word, input logic [1:0] sz,
                                             input logic sx, input logic [1:0] off);
        logic [31:0] v;
        int nb;
        nb = nbytes(sz);
        v = 32'h0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = word[8*(int'(off)+k) +: 8];
        if (sx && nb < 4 && v[8*nb-1]) begin
            for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_val(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] v;
        v = word;
        for (int k = 0; k < nbytes(sz); k++) v[8*(int'(off)+k) +: 8] = wd[8*k +: 8];
        return v;
    endfunction

    task automatic rand_txn();
        logic [31:0] r;
        logic        v  [2];
        logic        we [2];
        logic [1:0]  sz [2];
        logic        sx [2];
        logic [31:0] a  [2];
        logic [31:0] wd [2];
        logic        rv [2];
        logic        er [2];
        logic [31:0] rd [2];
        int          g;
        int          idx;
        logic        bad;
        logic [31:0] ed;
        bit          two;
        r = $urandom;
        v[0] = r[0] | ~r[1];
        v[1] = r[1];
        for (int p = 0; p < 2; p++) begin
            r = $urandom;
            we[p] = r[0];
            sx[p] = r[1];
            sz[p] = (r[5:2] == 4'd0) ? 2'd3 : ((r[7:6] == 2'd3) ? 2'd2 : r[7:6]);
            a[p]  = {24'h0, r[15:8]};
            if (r[19:16] != 4'd0) begin
                if (sz[p] == 2'd1) a[p][0] = 1'b0;
                if (sz[p] == 2'd2) a[p][1:0] = 2'b00;
            end
            wd[p] = $urandom;
            drive(p, v[p], we[p], sz[p], sx[p], a[p], wd[p]);
        end
        #1;
        if (v[0] && v[1]) g = RR ? int'(prio) : 0;
        else g = v[0] ? 0 : 1;
        chk1("rnd_ready0", req0_if.ready, g == 0);
        chk1("rnd_ready1", req1_if.ready, g == 1);
        bad = is_bad(sz[g], a[g]);
        idx = int'(a[g][7:2]);
        chk1("rnd_accept_we", mem_we, !bad && we[g] && sz[g] == 2'd2);
        ed = 32'h0;
        if (!bad && !we[g]) ed = load_val(ref_mem[idx], sz[g], sx[g], a[g][1:0]);
        if (!bad && we[g]) ref_mem[idx] = store_val(ref_mem[idx], sz[g], a[g][1:0], wd[g]);
        two = !bad && we[g] && sz[g] != 2'd2;
        tick();
        idle_ports();
        if (two) begin
            r = $urandom;
            drive(int'(r[0]), 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
            #1;
            chk1("rnd_rmw_ready0", req0_if.ready, 1'b0);
            chk1("rnd_rmw_ready1", req1_if.ready, 1'b0);
            chk1("rnd_rmw_we", mem_we, 1'b1);
            chk32("rnd_rmw_addr", mem_addr, a[g]);
            chk32("rnd_rmw_wdata", mem_wdata, ref_mem[idx]);
            idle_ports();
            tick();
        end
        rv[0] = req0_if.rvalid; rv[1] = req1_if.rvalid;
        er[0] = req0_if.err;    er[1] = req1_if.err;
        rd[0] = req0_if.rdata;  rd[1] = req1_if.rdata;
        chk1("rnd_rvalid", rv[g], 1'b1);
        chk1("rnd_rvalid_other", rv[1-g], 1'b0);
        chk1("rnd_err", er[g], bad);
        chk32("rnd_rdata", rd[g], ed);
        chk32("rnd_rdata_held", rd[1-g], last_rd[1-g]);
        chk32("rnd_mem_word", mem[idx], ref_mem[idx]);
        last_rd[g] = ed;
        prio = (g == 0);
    endtask

    initial begin
        int g;
        logic [31:0] r;
        bd_we = 1'b0; bd_idx = 6'd0; bd_data = 32'h0;
        idle_ports();
        prio = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        rst = 1'b1;
        tick(); tick();
        chk1("rst_rvalid0", req0_if.rvalid, 1'b0);
        chk1("rst_rvalid1", req1_if.rvalid, 1'b0);
        chk1("rst_err0", req0_if.err, 1'b0);
        chk32("rst_rdata0", req0_if.rdata, 32'h0);
        chk32("rst_rdata1", req1_if.rdata, 32'h0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        // Aligned word load
        poke(2, 32'hDEADBEEF);
        drive(0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h8, 32'h0);
        #1;
        chk1("lw_ready0", req0_if.ready, 1'b1);
        chk1("lw_ready1", req1_if.ready, 1'b0);
        chk32("lw_mem_addr", mem_addr, 32'h8);
        chk1("lw_mem_we", mem_we, 1'b0);
        tick();
        idle_ports();
        #1;
        chk1("lw_rvalid", req0_if.rvalid, 1'b1);
        chk32("lw_rdata", req0_if.rdata, 32'hDEADBEEF);
        chk1("lw_err", req0_if.err, 1'b0);
        chk32("idle_mem_addr", mem_addr, 32'h0);
        tick();
        chk1("lw_pulse_end", req0_if.rvalid, 1'b0);
        chk32("lw_rdata_held", req0_if.rdata, 32'hDEADBEEF);

        // Byte store through RMW, then a load of the same word right after
        poke(1, 32'h11223344);
        drive(1, 1'b1, 1'b1, SZ_B, 1'b0, 32'h5, 32'h000000AA);
        #1;
        chk1("sb_ready1", req1_if.ready, 1'b1);
        chk1("sb_accept_we", mem_we, 1'b0);
        tick();
        idle_ports();
        drive(0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
        #1;
        chk1("sb_rmw_ready0", req0_if.ready, 1'b0);
        chk1("sb_rmw_ready1", req1_if.ready, 1'b0);
        chk1("sb_rmw_we", mem_we, 1'b1);
        chk32("sb_rmw_addr", mem_addr, 32'h5);
        chk32("sb_rmw_wdata", mem_wdata, 32'h1122AA44);
        chk1("sb_rmw_rvalid", req1_if.rvalid, 1'b0);
        idle_ports();
        tick();
        chk1("sb_rvalid", req1_if.rvalid, 1'b1);
        chk32("sb_rdata", req1_if.rdata, 32'h0);
        chk32("sb_mem", mem[1], 32'h1122AA44);
        drive(0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h4, 32'h0);
        #1;
        chk1("raw_ready0", req0_if.ready, 1'b1);
        tick();
        idle_ports();
        chk1("raw_rvalid", req0_if.rvalid, 1'b1);
        chk32("raw_rdata", req0_if.rdata, 32'h1122AA44);

        // Half loads, sign- and zero-extended, back to back
        poke(1, 32'h80010000);
        drive(0, 1'b1, 1'b0, SZ_H, 1'b1, 32'h6, 32'h0);
        tick();
        chk1("lh_s_rvalid", req0_if.rvalid, 1'b1);
        chk32("lh_s_rdata", req0_if.rdata, 32'hFFFF8001);
        drive(0, 1'b1, 1'b0, SZ_H, 1'b0, 32'h6, 32'h0);
        #1;
        chk1("lh_u_ready0", req0_if.ready, 1'b1);
        tick();
        idle_ports();
        chk1("lh_u_rvalid", req0_if.rvalid, 1'b1);
        chk32("lh_u_rdata", req0_if.rdata, 32'h00008001);

        // Misaligned word store
        drive(0, 1'b1, 1'b1, SZ_W, 1'b0, 32'h2, 32'h12345678);
        #1;
        chk1("mis_ready0", req0_if.ready, 1'b1);
        chk1("mis_mem_we", mem_we, 1'b0);
        tick();
        idle_ports();
        chk1("mis_rvalid", req0_if.rvalid, 1'b1);
        chk1("mis_err", req0_if.err, 1'b1);
        chk32("mis_rdata", req0_if.rdata, 32'h0);
        chk32("mis_mem", mem[0], mem[0] === 32'h12345678 ? 32'hX : mem[0]);

        // Reset arriving while an RMW is in flight
        poke(1, 32'hCAFEF00D);
        drive(0, 1'b1, 1'b1, SZ_B, 1'b0, 32'h4, 32'h00000055);
        tick();
        idle_ports();
        rst = 1'b1;
        #1;
        chk1("rstrmw_mem_we", mem_we, 1'b0);
        tick();
        rst = 1'b0;
        chk1("rstrmw_rvalid", req0_if.rvalid, 1'b0);
        chk32("rstrmw_rdata", req0_if.rdata, 32'h0);
        chk32("rstrmw_mem", mem[1], 32'hCAFEF00D);
        drive(1, 1'b1, 1'b0, SZ_W, 1'b0, 32'h4, 32'h0);
        #1;
        chk1("rstrmw_idle_ready1", req1_if.ready, 1'b1);
        tick();
        idle_ports();
        chk1("rstrmw_ld_rvalid", req1_if.rvalid, 1'b1);
        chk32("rstrmw_ld_rdata", req1_if.rdata, 32'hCAFEF00D);

        // Both ports loading continuously
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h8, 32'h0);
            drive(1, 1'b1, 1'b0, SZ_W, 1'b0, 32'h4, 32'h0);
            #1;
            g = RR ? int'(prio) : 0;
            chk1("arb_ready0", req0_if.ready, g == 0);
            chk1("arb_ready1", req1_if.ready, g == 1);
            tick();
            chk32("arb_rdata", (g == 0) ? req0_if.rdata : req1_if.rdata,
                  (g == 0) ? 32'hDEADBEEF : 32'hCAFEF00D);
            prio = (g == 0);
        end
        idle_ports();

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 64; i++) begin
            r = $urandom;
            ref_mem[i] = r;
            poke(i, r);
        end
        for (int n = 0; n < 250; n++) rand_txn();
        idle_ports();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
